// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
// Bundles the two requester ports and the SRAM-controller side of the
// arbiter so they can be passed as one port.
//   port 0 (cache) : rdEn0In, wrEn0In, adr0In, wData0In -> rData0Out, ready0Out
//   port 1 (fetch) : rdEn1In, wrEn1In, adr1In, wData1In -> rData1Out, ready1Out
//   SRAM side      : sramRdEnOut, sramWrEnOut, sramAdrOut, sramWDataOut,
//                    sramReadDataIn, sramReadyIn
//   status         : busyOut
// Modport slave is the arbiter's view; master is the environment's view.
interface sram_arbiter_if;
    logic        rdEn0In;
    logic        wrEn0In;
    logic [31:0] adr0In;
    logic [31:0] wData0In;
    logic [63:0] rData0Out;
    logic        ready0Out;

    logic        rdEn1In;
    logic        wrEn1In;
    logic [31:0] adr1In;
    logic [31:0] wData1In;
    logic [31:0] rData1Out;
    logic        ready1Out;

    logic        sramRdEnOut;
    logic        sramWrEnOut;
    logic [31:0] sramAdrOut;
    logic [31:0] sramWDataOut;
    logic [63:0] sramReadDataIn;
    logic        sramReadyIn;

    logic        busyOut;

    modport slave (
        input  rdEn0In, wrEn0In, adr0In, wData0In,
        output rData0Out, ready0Out,
        input  rdEn1In, wrEn1In, adr1In, wData1In,
        output rData1Out, ready1Out,
        output sramRdEnOut, sramWrEnOut, sramAdrOut, sramWDataOut,
        input  sramReadDataIn, sramReadyIn,
        output busyOut
    );

    modport master (
        output rdEn0In, wrEn0In, adr0In, wData0In,
        input  rData0Out, ready0Out,
        output rdEn1In, wrEn1In, adr1In, wData1In,
        input  rData1Out, ready1Out,
        input  sramRdEnOut, sramWrEnOut, sramAdrOut, sramWDataOut,
        output sramReadDataIn, sramReadyIn,
        input  busyOut
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
// Shares one SRAM controller between the data-cache controller (port 0) and
// the instruction-fetch unit (port 1). One command is latched at a time, the
// SRAM enables are held until the controller completes, and the owner gets a
// one-cycle ready pulse with the read data. Ties go to the round-robin
// pointer, which always points away from the last port served.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : sram_arbiter_if.slave (requester ports, SRAM side, busyOut)
//
// state | meaning
// IDLE  | waiting for a request; grants on the clock a request is seen
// BUSY  | SRAM enable held from the latched command until sramReadyIn
// RESP  | enables low, one-cycle ready pulse to the owner
module sram_arbiter (
    input  logic                 clk,
    input  logic                 rst,
    sram_arbiter_if.slave        bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_owner;
    logic        r_rrPtr;
    logic        r_cmdWr;
    logic [31:0] r_cmdAdr;
    logic [31:0] r_cmdData;
    logic [63:0] r_rdLine;
    logic [31:0] r_rdWord1;
    logic        r_sramRdEn;
    logic        r_sramWrEn;
    logic        r_ready0;
    logic        r_ready1;
    logic        r_busy;

    logic        w_req0;
    logic        w_req1;
    logic        w_sel;
    logic        w_selWr;
    logic [31:0] w_selAdr;
    logic [31:0] w_selData;

    assign w_req0    = bus.rdEn0In | bus.wrEn0In;
    assign w_req1    = bus.rdEn1In | bus.wrEn1In;
    // Both requesting: the pointer decides; otherwise whichever port asks.
    assign w_sel     = (w_req0 && w_req1) ? r_rrPtr : w_req1;
    // A simultaneous read and write from one port is treated as a write.
    assign w_selWr   = w_sel ? bus.wrEn1In  : bus.wrEn0In;
    assign w_selAdr  = w_sel ? bus.adr1In   : bus.adr0In;
    assign w_selData = w_sel ? bus.wData1In : bus.wData0In;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= 1'b0;
            r_rrPtr    <= 1'b0;
            r_cmdWr    <= 1'b0;
            r_cmdAdr   <= 32'd0;
            r_cmdData  <= 32'd0;
            r_rdLine   <= 64'd0;
            r_rdWord1  <= 32'd0;
            r_sramRdEn <= 1'b0;
            r_sramWrEn <= 1'b0;
            r_ready0   <= 1'b0;
            r_ready1   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_ready0 <= 1'b0;
            r_ready1 <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_req0 || w_req1) begin
                        r_owner    <= w_sel;
                        r_cmdWr    <= w_selWr;
                        r_cmdAdr   <= w_selAdr;
                        r_cmdData  <= w_selData;
                        r_sramRdEn <= ~w_selWr;
                        r_sramWrEn <= w_selWr;
                        r_busy     <= 1'b1;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.sramReadyIn) begin
                        r_rdLine   <= bus.sramReadDataIn;
                        // Half-select uses the latched address so a fetch
                        // unit that has already moved on cannot corrupt it.
                        r_rdWord1  <= r_cmdAdr[2] ? bus.sramReadDataIn[63:32]
                                                  : bus.sramReadDataIn[31:0];
                        r_rrPtr    <= ~r_owner;
                        r_sramRdEn <= 1'b0;
                        r_sramWrEn <= 1'b0;
                        r_ready0   <= ~r_owner;
                        r_ready1   <= r_owner;
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_sramRdEn <= 1'b0;
                    r_sramWrEn <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.sramRdEnOut  = r_sramRdEn;
    assign bus.sramWrEnOut  = r_sramWrEn;
    assign bus.sramAdrOut   = r_cmdAdr;
    assign bus.sramWDataOut = r_cmdData;
    assign bus.rData0Out    = r_rdLine;
    assign bus.rData1Out    = r_rdWord1;
    assign bus.ready0Out    = r_ready0;
    assign bus.ready1Out    = r_ready1;
    assign bus.busyOut      = r_busy;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
// Directed stimulus for sram_arbiter with hand-computed expectations.
// Inputs are driven 1 time unit after the rising edge and outputs are
// checked at the same point, away from the active edge.
module tb_sram_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cnt;
    int   exp_port;

    sram_arbiter_if bus();

    sram_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.rdEn0In = 1'b0; bus.wrEn0In = 1'b0; bus.adr0In = 32'd0; bus.wData0In = 32'd0;
        bus.rdEn1In = 1'b0; bus.wrEn1In = 1'b0; bus.adr1In = 32'd0; bus.wData1In = 32'd0;
        bus.sramReadDataIn = 64'd0;
        bus.sramReadyIn    = 1'b0;

        // Reset values
        #12;
        chk("rst_rden",   {63'd0, bus.sramRdEnOut}, 64'd0);
        chk("rst_wren",   {63'd0, bus.sramWrEnOut}, 64'd0);
        chk("rst_adr",    {32'd0, bus.sramAdrOut}, 64'd0);
        chk("rst_wdata",  {32'd0, bus.sramWDataOut}, 64'd0);
        chk("rst_rdata0", bus.rData0Out, 64'd0);
        chk("rst_rdata1", {32'd0, bus.rData1Out}, 64'd0);
        chk("rst_ready",  {62'd0, bus.ready0Out, bus.ready1Out}, 64'd0);
        chk("rst_busy",   {63'd0, bus.busyOut}, 64'd0);
        tick();
        rst = 1'b0;

        // Contention: both ports request continuously, N=1 each
        bus.rdEn0In = 1'b1; bus.adr0In = 32'h10;
        bus.rdEn1In = 1'b1; bus.adr1In = 32'h20;
        for (int k = 0; k < 4; k++) begin
            exp_port = k % 2;
            tick();                                  // t+1
            chk("cont_busy", {63'd0, bus.busyOut}, 64'd1);
            chk("cont_rden", {63'd0, bus.sramRdEnOut}, 64'd1);
            chk("cont_adr", {32'd0, bus.sramAdrOut}, (exp_port == 1) ? 64'h20 : 64'h10);
            tick();                                  // t+2
            chk("cont_noready", {62'd0, bus.ready0Out, bus.ready1Out}, 64'd0);
            bus.sramReadyIn = 1'b1;
            bus.sramReadDataIn = 64'hC0DE_0000_0000_0000 | 64'(k);
            tick();                                  // t+3
            bus.sramReadyIn = 1'b0;
            chk("cont_ready0", {63'd0, bus.ready0Out}, (exp_port == 0) ? 64'd1 : 64'd0);
            chk("cont_ready1", {63'd0, bus.ready1Out}, (exp_port == 1) ? 64'd1 : 64'd0);
            chk("cont_rdata0", bus.rData0Out, 64'hC0DE_0000_0000_0000 | 64'(k));
            chk("cont_rdata1", {32'd0, bus.rData1Out}, 64'(k));
            tick();                                  // t+4 = IDLE
            chk("cont_idle", {63'd0, bus.busyOut}, 64'd0);
            if (k == 3) begin
                bus.rdEn0In = 1'b0;
                bus.rdEn1In = 1'b0;
            end
        end

        // Port 0 read alone, sramReadyIn 4 cycles after the enable
        bus.rdEn0In = 1'b1; bus.adr0In = 32'h40;
        cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (bus.sramRdEnOut === 1'b1) cnt++;
            if (i == 1) chk("p0rd_adr", {32'd0, bus.sramAdrOut}, 64'h40);
            if (i == 5) begin
                bus.sramReadyIn = 1'b1;
                bus.sramReadDataIn = 64'h1111_2222_3333_4444;
            end
        end
        tick();
        bus.sramReadyIn = 1'b0;
        chk("p0rd_en_cycles", 64'(cnt), 64'd5);
        chk("p0rd_en_low", {63'd0, bus.sramRdEnOut}, 64'd0);
        chk("p0rd_ready0", {63'd0, bus.ready0Out}, 64'd1);
        chk("p0rd_ready1", {63'd0, bus.ready1Out}, 64'd0);
        chk("p0rd_rdata0", bus.rData0Out, 64'h1111_2222_3333_4444);
        bus.rdEn0In = 1'b0;
        tick();
        chk("p0rd_pulse_end", {63'd0, bus.ready0Out}, 64'd0);
        chk("p0rd_idle", {63'd0, bus.busyOut}, 64'd0);

        // Port 1 read, upper word then lower word
        bus.rdEn1In = 1'b1; bus.adr1In = 32'h104;
        tick();
        chk("p1hi_adr", {32'd0, bus.sramAdrOut}, 64'h104);
        bus.sramReadyIn = 1'b1; bus.sramReadDataIn = 64'hAAAA_0000_BBBB_0000;
        tick();
        bus.sramReadyIn = 1'b0;
        chk("p1hi_ready1", {63'd0, bus.ready1Out}, 64'd1);
        chk("p1hi_ready0", {63'd0, bus.ready0Out}, 64'd0);
        chk("p1hi_rdata1", {32'd0, bus.rData1Out}, 64'hAAAA_0000);
        bus.rdEn1In = 1'b0;
        tick();
        bus.rdEn1In = 1'b1; bus.adr1In = 32'h100;
        tick();
        bus.sramReadyIn = 1'b1; bus.sramReadDataIn = 64'hAAAA_0000_BBBB_0000;
        tick();
        bus.sramReadyIn = 1'b0;
        chk("p1lo_ready1", {63'd0, bus.ready1Out}, 64'd1);
        chk("p1lo_rdata1", {32'd0, bus.rData1Out}, 64'hBBBB_0000);
        bus.rdEn1In = 1'b0;
        tick();

        // Port 0 write with both enables high
        bus.rdEn0In = 1'b1; bus.wrEn0In = 1'b1;
        bus.adr0In = 32'h80; bus.wData0In = 32'hDEAD_BEEF;
        tick();
        chk("wr_wren", {63'd0, bus.sramWrEnOut}, 64'd1);
        chk("wr_rden", {63'd0, bus.sramRdEnOut}, 64'd0);
        chk("wr_adr", {32'd0, bus.sramAdrOut}, 64'h80);
        chk("wr_wdata", {32'd0, bus.sramWDataOut}, 64'hDEAD_BEEF);
        tick();
        chk("wr_wren_hold", {63'd0, bus.sramWrEnOut}, 64'd1);
        chk("wr_wdata_hold", {32'd0, bus.sramWDataOut}, 64'hDEAD_BEEF);
        bus.sramReadyIn = 1'b1; bus.sramReadDataIn = 64'd0;
        tick();
        bus.sramReadyIn = 1'b0;
        chk("wr_ready0", {63'd0, bus.ready0Out}, 64'd1);
        chk("wr_wren_low", {63'd0, bus.sramWrEnOut}, 64'd0);
        bus.rdEn0In = 1'b0; bus.wrEn0In = 1'b0;
        tick();

        // Port 1 drops request and changes address during BUSY
        bus.rdEn1In = 1'b1; bus.adr1In = 32'h200;
        tick();
        chk("mid_adr", {32'd0, bus.sramAdrOut}, 64'h200);
        bus.rdEn1In = 1'b0; bus.adr1In = 32'h300;
        tick();
        chk("mid_adr_hold", {32'd0, bus.sramAdrOut}, 64'h200);
        chk("mid_busy", {63'd0, bus.busyOut}, 64'd1);
        bus.sramReadyIn = 1'b1; bus.sramReadDataIn = 64'h5555_6666_7777_8888;
        tick();
        bus.sramReadyIn = 1'b0;
        chk("mid_ready1", {63'd0, bus.ready1Out}, 64'd1);
        chk("mid_rdata1", {32'd0, bus.rData1Out}, 64'h7777_8888);
        tick();
        chk("mid_no_regrant", {63'd0, bus.busyOut}, 64'd0);

        // Port 0 read so the pointer favours port 1, then reset mid-transfer
        bus.rdEn0In = 1'b1; bus.adr0In = 32'h40;
        tick();
        bus.sramReadyIn = 1'b1;
        tick();
        bus.sramReadyIn = 1'b0;
        bus.rdEn0In = 1'b0;
        tick();
        bus.rdEn1In = 1'b1; bus.adr1In = 32'h300;
        tick();
        chk("ar_rden_before", {63'd0, bus.sramRdEnOut}, 64'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_rden_drop", {63'd0, bus.sramRdEnOut}, 64'd0);
        chk("ar_busy_drop", {63'd0, bus.busyOut}, 64'd0);
        tick();
        chk("ar_no_ready", {62'd0, bus.ready0Out, bus.ready1Out}, 64'd0);
        bus.rdEn0In = 1'b1; bus.adr0In = 32'h44;
        bus.rdEn1In = 1'b1; bus.adr1In = 32'h304;
        rst = 1'b0;
        tick();
        chk("ar_tie_port0", {32'd0, bus.sramAdrOut}, 64'h44);
        bus.sramReadyIn = 1'b1;
        tick();
        bus.sramReadyIn = 1'b0;
        chk("ar_ready0", {63'd0, bus.ready0Out}, 64'd1);
        bus.rdEn0In = 1'b0; bus.rdEn1In = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single SRAM controller of the ARM pipeline between the data-side cache controller (port 0) and the instruction-fetch unit (port 1). It latches one requester's command, holds the SRAM controller's enables until the transfer completes, and returns the read data with a one-cycle ready pulse to the winner. Round-robin arbitration prevents starvation. It sits between the requesters and the SRAM controller, replacing the direct cache-to-SRAM enable wiring.

## Interface
- No parameters; all widths are fixed.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdEn0In, wrEn0In  in  1 each  port 0 (cache) read/write request; level, held until ready0Out.
- adr0In  in  32  port 0 byte address.
- wData0In  in  32  port 0 write data.
- rData0Out  out  64  port 0 read data (full 64-bit SRAM line).
- ready0Out  out  1  port 0 completion, one-cycle pulse.
- rdEn1In, wrEn1In  in  1 each  port 1 (fetch) read/write request; level, held until ready1Out.
- adr1In  in  32  port 1 byte address.
- wData1In  in  32  port 1 write data.
- rData1Out  out  32  port 1 read word: adr[2]=1 gives upper half of the line, else lower half.
- ready1Out  out  1  port 1 completion, one-cycle pulse.
- sramRdEnOut, sramWrEnOut  out  1 each  enables to the SRAM controller.
- sramAdrOut  out  32  latched address.
- sramWDataOut  out  32  latched write data.
- sramReadDataIn  in  64  line from the SRAM controller.
- sramReadyIn  in  1  SRAM controller completion; one-cycle pulse.
- busyOut  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, BUSY, RESP. Registers: state, owner (1 bit), rrPtr (1 bit, preferred port), cmdWr, cmdAdr, cmdData, rdLine (64).
- A port is requesting when rdEn or wrEn is high. If both are high, the command is a write.
- IDLE: if exactly one port requests, grant it. If both request, grant rrPtr. On a grant, latch owner, cmdWr, address and data, then go to BUSY. With no request, stay in IDLE.
- BUSY: drive sramRdEnOut = !cmdWr and sramWrEnOut = cmdWr continuously, with sramAdrOut and sramWDataOut taken from the latch. On sramReadyIn: capture sramReadDataIn into rdLine, set rrPtr = ~owner, go to RESP.
- RESP: both SRAM enables low. Pulse ready for the owner only. Go to IDLE.
- The rData outputs are registered and hold the last line; they are valid for reads during the ready pulse. After a write they are don't-care.
- rData1Out selects its half of the line using the latched cmdAdr[2], not the live adr1In.
- A requester that drops its request while in BUSY does not abort the transfer. The transfer completes and the ready pulse still fires.
- Request inputs and the other port's address and data are ignored outside IDLE.
- sramReadyIn is ignored in IDLE and RESP.

## Timing
- Reset (asynchronous): state=IDLE, rrPtr=0, owner=0. All outputs 0: both enables, sramAdrOut, sramWDataOut, rData0Out, rData1Out, both ready pulses, busyOut.
- Reset in mid-transfer drops the transfer with no ready pulse. The SRAM enables fall immediately.
- Timeline for a request seen in IDLE at cycle t:
  - the SRAM enable is high from t+1;
  - if sramReadyIn arrives at cycle t+1+N (N≥0), the enable is low and the owner's ready pulse is high at t+2+N;
  - IDLE resumes at t+3+N.
- Minimum turnaround is 3 cycles per transaction.
- A request still held in the first IDLE cycle after the ready pulse is treated as a new transaction. Requesters must drop or change the request on the cycle they see ready.
- busyOut is high from t+1 through t+2+N.
- ready0Out and ready1Out are never high in the same cycle.

## Test plan
- Port 0 read alone: adr0In=0x40, sramReadyIn 4 cycles after the enable, sramReadDataIn=0x11112222_33334444. Required: sramRdEnOut high for exactly 5 cycles with sramAdrOut=0x40, then ready0Out pulses 1 cycle with rData0Out=0x11112222_33334444, and ready1Out stays 0.
- Port 1 read, upper word: adr1In=0x104, line 0xAAAA0000_BBBB0000. Required: rData1Out=0xAAAA0000 with ready1Out. Repeat with adr1In=0x100; required rData1Out=0xBBBB0000.
- Simultaneous contention: after reset, both ports request continuously. Required: the grant order is 0,1,0,1, the ready pulses alternate, and each transaction is 3+N cycles.
- Port 0 write: wrEn0In=1, rdEn0In=1, adr0In=0x80, wData0In=0xDEADBEEF. Required: sramWrEnOut=1 and sramRdEnOut=0, with sramAdrOut=0x80 and sramWDataOut=0xDEADBEEF held until sramReadyIn, then ready0Out pulses.
- Mid-transfer changes: port 1 drops its request and changes adr1In during BUSY. Required: sramAdrOut is unchanged and ready1Out still pulses.
- Asynchronous reset mid-transfer: assert rst during BUSY, between clock edges. Required: enables and busyOut drop before the next edge, no ready pulse, and after release port 0 wins a tie.
